// File: rtl/jtag_dr_pkg.sv
// rtl/jtag_dr_pkg.sv - instruction map, DR length decode and bridge FSM states for jtag_dr_bank.
// JTAG_DR_STATUS_EN adds the 8-bit status register at insn 73.
package jtag_dr_pkg;

  localparam logic [7:0] INSN_SQ_FIRST     = 8'd1;
  localparam logic [7:0] INSN_SQ_LAST      = 8'd64;
  localparam logic [7:0] INSN_STATE_MODE   = 8'd65;
  localparam logic [7:0] INSN_MASK_MODE    = 8'd66;
  localparam logic [7:0] INSN_WTM          = 8'd67;
  localparam logic [7:0] INSN_WRITE_BUS    = 8'd68;
  localparam logic [7:0] INSN_SS1          = 8'd69;
  localparam logic [7:0] INSN_SS2          = 8'd70;
  localparam logic [7:0] INSN_BOARD_STATUS = 8'd71;
  localparam logic [7:0] INSN_CORE_SEL     = 8'd72;
  localparam logic [7:0] INSN_DR_STATUS    = 8'd73;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} dr_fsm_t;

  function automatic logic is_sq(input logic [7:0] insn);
    return (insn >= INSN_SQ_FIRST) && (insn <= INSN_SQ_LAST);
  endfunction

  function automatic logic [3:0] dr_len(input logic [7:0] insn);
    logic [3:0] len;
    len = 4'd1;
    if (is_sq(insn)) len = 4'd5;
    else begin
      case (insn)
        INSN_STATE_MODE:   len = 4'd3;
        INSN_MASK_MODE:    len = 4'd2;
        INSN_WTM:          len = 4'd1;
        INSN_WRITE_BUS:    len = 4'd4;
        INSN_SS1:          len = 4'd7;
        INSN_SS2:          len = 4'd7;
        INSN_BOARD_STATUS: len = 4'd8;
        INSN_CORE_SEL:     len = 4'd3;
`ifdef JTAG_DR_STATUS_EN
        INSN_DR_STATUS:    len = 4'd8;
`endif
        default:           len = 4'd1;
      endcase
    end
    return len;
  endfunction

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    return 8'((9'd1 << len) - 9'd1);
  endfunction

endpackage

// File: rtl/jtag_dr_sq_bridge.sv
// rtl/jtag_dr_sq_bridge.sv - square/status read and square write handshake FSM with timeout and sticky errors.
module jtag_dr_sq_bridge import jtag_dr_pkg::*; #(
  parameter int RD_TIMEOUT = 15,
  parameter int SQ_BITS    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         insn,
  input  logic               capture,
  input  logic               shift,
  input  logic               update,
  input  logic [SQ_BITS-1:0] wr_payload,
  input  logic               clr_rd_err,
  input  logic               clr_wr_ovf,
  output logic               sq_rd_req,
  output logic [6:0]         sq_addr,
  input  logic               sq_rd_ack,
  output logic               sq_wr_req,
  output logic [SQ_BITS-1:0] sq_wr_data,
  input  logic               sq_wr_ack,
  output logic               rd_load,
  output logic               rd_err,
  output logic               wr_ovf
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  dr_fsm_t       state;
  logic [CW-1:0] cnt;
  logic          cap_pend;
  logic [6:0]    pend_addr;
  logic          is_rd, upd_wr;

  assign is_rd  = is_sq(insn) || (insn == INSN_BOARD_STATUS);
  assign upd_wr = update && is_sq(insn);
  assign rd_load = (state == RD_WAIT) && sq_rd_ack && !capture && !shift && !upd_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sq_rd_req  <= 1'b0;
      sq_wr_req  <= 1'b0;
      sq_addr    <= '0;
      sq_wr_data <= '0;
      cnt        <= '0;
      cap_pend   <= 1'b0;
      pend_addr  <= '0;
      rd_err     <= 1'b0;
      wr_ovf     <= 1'b0;
    end else begin
      if (clr_rd_err) rd_err <= 1'b0;
      if (clr_wr_ovf) wr_ovf <= 1'b0;
      // A deferred capture is superseded by any later capture or shift.
      if (cap_pend && (capture || shift)) begin
        cap_pend <= 1'b0;
        if (shift) rd_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture && is_rd) begin
            sq_rd_req <= 1'b1;
            sq_addr   <= insn[6:0];
            cnt       <= '0;
            state     <= RD_WAIT;
          end else if (upd_wr) begin
            sq_wr_req  <= 1'b1;
            sq_addr    <= insn[6:0];
            sq_wr_data <= wr_payload;
            state      <= WR_WAIT;
          end else if (cap_pend && !shift && !capture) begin
            cap_pend  <= 1'b0;
            sq_rd_req <= 1'b1;
            sq_addr   <= pend_addr;
            cnt       <= '0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (capture || shift) begin
            sq_rd_req <= 1'b0;
            rd_err    <= 1'b1;
            state     <= IDLE;
            if (capture && is_rd) begin
              cap_pend  <= 1'b1;
              pend_addr <= insn[6:0];
            end
          end else if (upd_wr) begin
            sq_rd_req  <= 1'b0;
            rd_err     <= 1'b1;
            sq_wr_req  <= 1'b1;
            sq_addr    <= insn[6:0];
            sq_wr_data <= wr_payload;
            state      <= WR_WAIT;
          end else if (sq_rd_ack) begin
            sq_rd_req <= 1'b0;
            state     <= IDLE;
          end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
            sq_rd_req <= 1'b0;
            rd_err    <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (capture && is_rd) begin
            cap_pend  <= 1'b1;
            pend_addr <= insn[6:0];
          end
          if (upd_wr) wr_ovf <= 1'b1;
          if (sq_wr_ack) begin
            sq_wr_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dr_bank.sv
// rtl/jtag_dr_bank.sv - user DR bank: shared shift register, config registers, board bridge.
// JTAG_DR_STATUS_EN exposes {wr_ovf, rd_err} as a W1C register at insn 73.
module jtag_dr_bank import jtag_dr_pkg::*; #(
  parameter int RD_TIMEOUT = 15,
  parameter int SQ_BITS    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         insn,
  input  logic               dr_tdi,
  output logic               dr_tdo,
  input  logic               dr_capture,
  input  logic               dr_shift,
  input  logic               dr_update,
  output logic               sq_rd_req,
  output logic [6:0]         sq_addr,
  input  logic               sq_rd_ack,
  input  logic [7:0]         sq_rd_data,
  output logic               sq_wr_req,
  output logic [SQ_BITS-1:0] sq_wr_data,
  input  logic               sq_wr_ack,
  output logic [2:0]         state_mode,
  output logic [1:0]         mask_mode,
  output logic               wtm,
  output logic [3:0]         write_bus,
  output logic [6:0]         ss1,
  output logic [6:0]         ss2,
  output logic [2:0]         core_sel,
  output logic               cfg_updated
);

  logic [7:0] sr, mask, cap_val, shift_in;
  logic [3:0] len;
  logic       cap, sh, upd, is_cfg, rd_load, rd_err, wr_ovf, clr_rd_err, clr_wr_ovf;

  assign len      = dr_len(insn);
  assign mask     = len_mask(len);
  assign cap      = dr_capture;
  assign sh       = dr_shift && !dr_capture;
  assign upd      = dr_update && !dr_capture && !dr_shift;
  assign dr_tdo   = sr[0];
  assign shift_in = {7'd0, dr_tdi} << (len - 4'd1);

  // Capture value is zero for square, board-status and dummy registers.
  always_comb begin
    cap_val = 8'd0;
    is_cfg  = 1'b1;
    case (insn)
      INSN_STATE_MODE: cap_val = {5'd0, state_mode};
      INSN_MASK_MODE:  cap_val = {6'd0, mask_mode};
      INSN_WTM:        cap_val = {7'd0, wtm};
      INSN_WRITE_BUS:  cap_val = {4'd0, write_bus};
      INSN_SS1:        cap_val = {1'b0, ss1};
      INSN_SS2:        cap_val = {1'b0, ss2};
      INSN_CORE_SEL:   cap_val = {5'd0, core_sel};
`ifdef JTAG_DR_STATUS_EN
      INSN_DR_STATUS: begin
        is_cfg  = 1'b0;
        cap_val = {6'd0, wr_ovf, rd_err};
      end
`endif
      default:         is_cfg = 1'b0;
    endcase
  end

`ifdef JTAG_DR_STATUS_EN
  assign clr_rd_err = upd && (insn == INSN_DR_STATUS) && sr[0];
  assign clr_wr_ovf = upd && (insn == INSN_DR_STATUS) && sr[1];
`else
  logic unused_flags;
  assign clr_rd_err   = 1'b0;
  assign clr_wr_ovf   = 1'b0;
  assign unused_flags = rd_err ^ wr_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else if (cap) sr <= cap_val;
    else if (sh) sr <= ((sr >> 1) | shift_in) & mask;
    else if (rd_load) sr <= sq_rd_data & mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_mode  <= '0;
      mask_mode   <= '0;
      wtm         <= 1'b1;
      write_bus   <= '0;
      ss1         <= '0;
      ss2         <= '0;
      core_sel    <= '0;
      cfg_updated <= 1'b0;
    end else begin
      cfg_updated <= upd && is_cfg;
      if (upd) begin
        case (insn)
          INSN_STATE_MODE: state_mode <= sr[2:0];
          INSN_MASK_MODE:  mask_mode  <= sr[1:0];
          INSN_WTM:        wtm        <= sr[0];
          INSN_WRITE_BUS:  write_bus  <= sr[3:0];
          INSN_SS1:        ss1        <= sr[6:0];
          INSN_SS2:        ss2        <= sr[6:0];
          INSN_CORE_SEL:   core_sel   <= sr[2:0];
          default: ;
        endcase
      end
    end
  end

  jtag_dr_sq_bridge #(
    .RD_TIMEOUT (RD_TIMEOUT),
    .SQ_BITS    (SQ_BITS)
  ) u_bridge (
    .clk        (clk),
    .rst        (rst),
    .insn       (insn),
    .capture    (cap),
    .shift      (sh),
    .update     (upd),
    .wr_payload (sr[SQ_BITS-1:0]),
    .clr_rd_err (clr_rd_err),
    .clr_wr_ovf (clr_wr_ovf),
    .sq_rd_req  (sq_rd_req),
    .sq_addr    (sq_addr),
    .sq_rd_ack  (sq_rd_ack),
    .sq_wr_req  (sq_wr_req),
    .sq_wr_data (sq_wr_data),
    .sq_wr_ack  (sq_wr_ack),
    .rd_load    (rd_load),
    .rd_err     (rd_err),
    .wr_ovf     (wr_ovf)
  );

endmodule
